// File: rtl/fifo_1wmr_pkg.sv
// Shared types for the single-write / multi-read retire queue.
package fifo_1wmr_pkg;

  // Default number of entries the retire stage consumes per cycle.
  localparam int unsigned RETIRE_WIDTH = 4;

  typedef logic [$clog2(RETIRE_WIDTH):0] retire_cnt_t;

  // Commit-stage record carried through the queue.
  typedef logic [63:0] commit_instr_t;

endpackage

// File: rtl/fifo_bank.sv
// One storage bank of fifo_1wmr: single write port, asynchronous single read port.
// Contents are intentionally not reset.
module fifo_bank #(
  parameter type         TYPE  = logic [63:0],
  parameter int unsigned Depth = 4,
  parameter int unsigned RowW  = 2
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [RowW-1:0] waddr_i,
  input  TYPE             wdata_i,
  input  logic [RowW-1:0] raddr_i,
  output TYPE             rdata_o
);

  TYPE mem_q [Depth];

  // Write the row selected by the producer-side pointer.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_1wmr.sv
// Single-write, multi-read in-order queue. Entry p lives in bank p mod RNUM, so the RNUM
// oldest entries always sit in distinct banks; read ports are rotated by head's low bits.
// Optional same-cycle bypass when empty: define FIFO_1WMR_BYPASS_EN.
module fifo_1wmr
  import fifo_1wmr_pkg::*;
#(
  parameter int unsigned QLEN = 16,
  parameter type         TYPE = commit_instr_t,
  parameter int unsigned RNUM = RETIRE_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  TYPE                   push_data_i,
  output logic [RNUM-1:0]       out_valid_o,
  output TYPE  [RNUM-1:0]       out_data_o,
  input  logic [$clog2(RNUM):0] pop_cnt_i,
  output logic [$clog2(QLEN):0] count_o
);

  localparam int unsigned PtrW  = $clog2(QLEN) + 1;
  localparam int unsigned AW    = $clog2(QLEN);
  localparam int unsigned BW    = $clog2(RNUM);
  localparam int unsigned Depth = QLEN / RNUM;
  localparam int unsigned RowW  = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PtrW-1:0] count, pop_ext, pop_eff;
  logic            push_fire, bypass_take;
  logic [RowW-1:0] wr_row;
  TYPE  [RNUM-1:0] rdata;
  logic [RNUM-1:0] valid_raw;
  TYPE  [RNUM-1:0] data_raw;

  // Wrap bit distinguishes full from empty, so plain subtraction gives occupancy.
  assign count        = tail_q - head_q;
  assign count_o      = count;
  assign push_ready_o = (count != PtrW'(QLEN));
  assign pop_ext      = PtrW'(pop_cnt_i);
  assign pop_eff      = (pop_ext > count) ? count : pop_ext;

`ifdef FIFO_1WMR_BYPASS_EN
  logic empty;
  assign empty       = (count == '0);
  // Consumed straight from the producer; never written to storage.
  assign bypass_take = empty && push_valid_i && (pop_cnt_i != '0);
`else
  assign bypass_take = 1'b0;
`endif

  assign push_fire = push_valid_i && push_ready_o && !bypass_take;
  assign wr_row    = RowW'(tail_q[AW-1:0] >> BW);

  // Pointer next-state: pops clamped to occupancy, pushes by handshake.
  always_comb begin
    head_d = head_q + pop_eff;
    tail_d = tail_q + PtrW'(push_fire);
  end

  // Pointer registers; asynchronous reset empties the queue at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  for (genvar b = 0; b < RNUM; b++) begin : g_bank
    logic [BW-1:0] port_idx;
    logic [AW-1:0] rd_addr;
    // Bank b serves the read port whose address head+i lands in it.
    assign port_idx = BW'(b) - head_q[BW-1:0];
    assign rd_addr  = head_q[AW-1:0] + AW'(port_idx);

    fifo_bank #(
      .TYPE  (TYPE),
      .Depth (Depth),
      .RowW  (RowW)
    ) u_bank (
      .clk_i   (clk_i),
      .we_i    (push_fire && (tail_q[BW-1:0] == BW'(b))),
      .waddr_i (wr_row),
      .wdata_i (push_data_i),
      .raddr_i (RowW'(rd_addr >> BW)),
      .rdata_o (rdata[b])
    );
  end

  for (genvar i = 0; i < RNUM; i++) begin : g_port
    logic [BW-1:0] bank_sel;
    assign bank_sel     = head_q[BW-1:0] + BW'(i);
    assign valid_raw[i] = (count > PtrW'(i));
    assign data_raw[i]  = rdata[bank_sel];
  end

  // Output ports, with optional empty-queue forwarding onto port 0.
  always_comb begin
    out_valid_o = valid_raw;
    out_data_o  = data_raw;
`ifdef FIFO_1WMR_BYPASS_EN
    if (empty && push_valid_i) begin
      out_valid_o[0] = 1'b1;
      out_data_o[0]  = push_data_i;
    end
`endif
  end

endmodule

// File: tb/tb_fifo_1wmr.sv
// Bench for fifo_1wmr: directed stimulus plus a queue scoreboard checked every cycle.
module tb_fifo_1wmr;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            push_valid;
  logic            push_ready;
  logic [63:0]     push_data;
  logic [3:0]      out_valid;
  logic [3:0][63:0] out_data;
  logic [2:0]      pop_cnt;
  logic [4:0]      count;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_1wmr #(
    .QLEN (16),
    .TYPE (logic [63:0]),
    .RNUM (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .push_valid_i (push_valid),
    .push_ready_o (push_ready),
    .push_data_i  (push_data),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .pop_cnt_i    (pop_cnt),
    .count_o      (count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares presented outputs with expected contents, then
  // retires what the consumer takes and enqueues what the producer gets accepted.
  always @(negedge clk) begin : monitor
    int sz;
    int pe;
    logic [3:0] ev;
    logic byp;
    if (!rst_n) begin
      exp_q.delete();
      chk("sb_rst_count", 64'(count), 64'd0);
    end else begin
      sz  = exp_q.size();
      byp = 1'b0;
`ifdef FIFO_1WMR_BYPASS_EN
      byp = (sz == 0) && push_valid;
`endif
      for (int i = 0; i < 4; i++) ev[i] = (sz > i);
      if (byp) ev[0] = 1'b1;
      chk("sb_count", 64'(count), 64'(sz));
      chk("sb_push_ready", 64'(push_ready), 64'(sz != 16));
      chk("sb_out_valid", 64'(out_valid), 64'(ev));
      for (int i = 0; i < 4; i++) begin
        if (i < sz) chk("sb_out_data", out_data[i], exp_q[i]);
      end
      if (byp) chk("sb_bypass_data", out_data[0], push_data);
      if (!(byp && pop_cnt != 3'd0)) begin
        pe = (int'(pop_cnt) > sz) ? sz : int'(pop_cnt);
        for (int k = 0; k < pe; k++) void'(exp_q.pop_front());
        if (push_valid && sz != 16) exp_q.push_back(push_data);
      end
    end
  end

  // Called at posedge+2; leaves inputs idle at the following posedge+2.
  task automatic step(input logic pv, input logic [63:0] pd, input logic [2:0] pc);
    push_valid = pv;
    push_data  = pd;
    pop_cnt    = pc;
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    pop_cnt    = 3'd0;
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    push_valid = 1'b0;
    push_data  = '0;
    pop_cnt    = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("idle_count", 64'(count), 64'd0);
    chk("idle_valid", 64'(out_valid), 64'h0);
    chk("idle_ready", 64'(push_ready), 64'd1);

    // Three pushes, no pops.
    step(1'b1, 64'h10, 3'd0);
    step(1'b1, 64'h11, 3'd0);
    step(1'b1, 64'h12, 3'd0);
    chk("p3_count", 64'(count), 64'd3);
    chk("p3_valid", 64'(out_valid), 64'h7);
    chk("p3_d0", out_data[0], 64'h10);
    chk("p3_d1", out_data[1], 64'h11);
    chk("p3_d2", out_data[2], 64'h12);

    // Push and pop together at count 3.
    step(1'b1, 64'h20, 3'd1);
    chk("pp_count", 64'(count), 64'd3);
    chk("pp_d0", out_data[0], 64'h11);
    chk("pp_d2", out_data[2], 64'h20);
    step(1'b0, 64'h0, 3'd4);
    chk("drain_count", 64'(count), 64'd0);

    // Over-pop is clamped; head now misaligned with bank 0.
    step(1'b1, 64'hA, 3'd0);
    step(1'b1, 64'hB, 3'd0);
    step(1'b0, 64'h0, 3'd4);
    chk("clamp_count", 64'(count), 64'd0);
    chk("clamp_valid", 64'(out_valid), 64'h0);
    step(1'b1, 64'hC, 3'd0);
    chk("clamp_count1", 64'(count), 64'd1);
    chk("clamp_d0", out_data[0], 64'hC);
    step(1'b0, 64'h0, 3'd1);

    // Asynchronous reset with five entries held.
    for (int v = 0; v < 5; v++) step(1'b1, 64'(v + 'h40), 3'd0);
    chk("pre_rst_count", 64'(count), 64'd5);
    rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'h0);
    chk("arst_ready", 64'(push_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;

    // Fill to full, then a refused push alongside a pop of 2.
    for (int v = 0; v < 16; v++) step(1'b1, 64'(v), 3'd0);
    chk("full_count", 64'(count), 64'd16);
    chk("full_ready", 64'(push_ready), 64'd0);
    step(1'b1, 64'h99, 3'd2);
    chk("refuse_count", 64'(count), 64'd14);
    chk("refuse_d0", out_data[0], 64'd2);
    for (int k = 0; k < 4; k++) step(1'b0, 64'h0, 3'd4);
    chk("drain2_count", 64'(count), 64'd0);

    // Wrap-around with head low bits nonzero.
    step(1'b1, 64'h77, 3'd0);
    step(1'b0, 64'h0, 3'd1);
    for (int v = 0; v < 16; v++) step(1'b1, 64'(v), 3'd0);
    for (int k = 0; k < 3; k++) step(1'b0, 64'h0, 3'd4);
    chk("wrap_count4", 64'(count), 64'd4);
    for (int v = 16; v < 28; v++) step(1'b1, 64'(v), 3'd0);
    chk("wrap_count16", 64'(count), 64'd16);
    for (int i = 0; i < 4; i++) chk("wrap_a", out_data[i], 64'(12 + i));
    step(1'b0, 64'h0, 3'd4);
    for (int i = 0; i < 4; i++) chk("wrap_b", out_data[i], 64'(16 + i));
    for (int k = 0; k < 3; k++) step(1'b0, 64'h0, 3'd4);
    chk("wrap_drain", 64'(count), 64'd0);

    // Push with pop at empty: forwarded with bypass, else enqueued.
    push_valid = 1'b1;
    push_data  = 64'h30;
    pop_cnt    = 3'd1;
    #1;
`ifdef FIFO_1WMR_BYPASS_EN
    chk("byp_valid0", 64'(out_valid[0]), 64'd1);
    chk("byp_d0", out_data[0], 64'h30);
`else
    chk("nobyp_valid", 64'(out_valid), 64'h0);
`endif
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    pop_cnt    = 3'd0;
    #1;
`ifdef FIFO_1WMR_BYPASS_EN
    chk("byp_count", 64'(count), 64'd0);
`else
    chk("nobyp_count", 64'(count), 64'd1);
    chk("nobyp_d0", out_data[0], 64'h30);
`endif
    step(1'b0, 64'h0, 3'd4);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
